// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable LEGv8 instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  // CBZ XZR,0: spins in place, so loaders pad unused words with it.
  localparam logic [31:0] HALT_INSN = 32'hb400001f;

endpackage

// File: rtl/imem_ram.sv
// Single write port, synchronous read port word array; contents are never reset.
module imem_ram #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_q;

  // Read register only updates on a read, so the last fetched word is held.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_prog.sv
// Loadable instruction memory: streams a program image in over valid/ready, then serves
// registered fetches with range checking against the number of words loaded.
module imem_prog
  import imem_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_en,
  input  logic          prog_valid,
  input  logic [N-1:0]  prog_data,
  output logic          prog_ready,
  output logic          prog_done,
  output logic [AW:0]   prog_count,
  input  logic          fetch_req,
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic          oob_err,
  output logic          busy
);

  localparam logic [AW:0] DepthW = DEPTH[AW:0];
  localparam logic [AW:0] OneW   = {{AW{1'b0}}, 1'b1};

  imem_state_t state_q, state_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] count_q, count_d;
  logic        q_valid_q, q_valid_d;
  logic        oob_q, oob_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;

  logic        accept;
  logic        ram_we;
  logic        ram_re;
  logic [AW:0] addr_ext;
  logic [N-1:0] ram_rdata;

  assign addr_ext = {1'b0, addr};
  assign prog_ready = (state_q == LOAD) && (wptr_q < DepthW);
  assign accept = prog_ready && prog_valid;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    q_valid_d = 1'b0;
    oob_d     = 1'b0;
    done_d    = 1'b0;
    zero_d    = zero_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (prog_en) begin
          state_d = LOAD;
          wptr_d  = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          ram_we = 1'b1;
          wptr_d = wptr_q + OneW;
        end
        // Either the loader ends early or the last slot has just been written.
        if (!prog_en || (accept && (wptr_q == (DepthW - OneW)))) begin
          state_d = RUN;
          count_d = wptr_d;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (prog_en) begin
          state_d = LOAD;
          wptr_d  = '0;
          count_d = '0;
        end else if (fetch_req) begin
          q_valid_d = 1'b1;
          oob_d     = (addr_ext >= count_q);
          zero_d    = oob_d;
          ram_re    = !oob_d;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      count_q   <= '0;
      q_valid_q <= 1'b0;
      oob_q     <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      q_valid_q <= q_valid_d;
      oob_q     <= oob_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  imem_ram #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (prog_data),
    .re_i    (ram_re),
    .raddr_i (addr),
    .rdata_o (ram_rdata)
  );

  // zero_q masks the unreset read register and forces 0 after an out-of-range fetch.
  assign q          = zero_q ? '0 : ram_rdata;
  assign q_valid    = q_valid_q;
  assign oob_err    = oob_q;
  assign prog_done  = done_q;
  assign prog_count = count_q;
  assign busy       = (state_q == LOAD);

endmodule
